// File: rtl/fp_pkg.sv
// Shared constants and pipeline payload for the FP adder post-normalisation path.
package fp_pkg;
  localparam int WIDTH   = 48;
  localparam int MAN_W   = 24;
  localparam int EXP_W   = 8;
  localparam int EXP_MAX = 2**EXP_W - 1;
  localparam int SEXP_W  = EXP_W + 2;
  localparam int LZC_W   = $clog2(WIDTH + 1);
  localparam int STAGES  = 3;

  typedef struct packed {
    logic [WIDTH:0]           man;
    logic signed [SEXP_W-1:0] exp;
    logic                     sign;
    logic                     sticky;
    logic                     zero;
  } stage_t;
endpackage

// File: rtl/fp_normalize_round_if.sv
// Upstream and downstream valid/ready channels of the normalise/round stage.
interface fp_normalize_round_if;
  import fp_pkg::*;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   sum_in;
  logic [EXP_W-1:0] exp_in;
  logic             sign_in;
  logic             out_valid;
  logic             out_ready;
  logic [MAN_W-1:0] man_out;
  logic [EXP_W-1:0] exp_out;
  logic             sign_out;
  logic             zero;
  logic             ovf;
  logic             unf;

  modport master (
    output in_valid, sum_in, exp_in, sign_in, out_ready,
    input  in_ready, out_valid, man_out, exp_out, sign_out, zero, ovf, unf
  );
  modport slave (
    input  in_valid, sum_in, exp_in, sign_in, out_ready,
    output in_ready, out_valid, man_out, exp_out, sign_out, zero, ovf, unf
  );
endinterface

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter built as a binary tree of half-width counters.
module fp_lzc
  import fp_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0]           din,
  output logic [$clog2(W+1)-1:0] cnt,
  output logic                   all_zero
);
  localparam int CW = $clog2(W + 1);

  generate
    if (W == 1) begin : g_leaf
      assign all_zero = ~din[0];
      assign cnt      = CW'(~din[0]);
    end else begin : g_node
      localparam int HI = W - W / 2;
      localparam int LO = W / 2;
      logic [$clog2(HI+1)-1:0] c_hi;
      logic [$clog2(LO+1)-1:0] c_lo;
      logic                    z_hi, z_lo;

      fp_lzc #(.W(HI)) u_hi (.din(din[W-1:LO]), .cnt(c_hi), .all_zero(z_hi));
      fp_lzc #(.W(LO)) u_lo (.din(din[LO-1:0]), .cnt(c_lo), .all_zero(z_lo));

      assign all_zero = z_hi & z_lo;
      assign cnt      = z_hi ? CW'(HI) + CW'(c_lo) : CW'(c_hi);
    end
  endgenerate
endmodule

// File: rtl/fp_normalize_round.sv
// Post-adder normalise + round-to-nearest-even, 3-stage valid/ready pipeline.
module fp_normalize_round
  import fp_pkg::*;
(
  input logic                 CLK,
  input logic                 RST,
  fp_normalize_round_if.slave io
);
  logic [STAGES:1]          vld_pipe;
  logic                     rdy1, rdy2, rdy3;
  stage_t                   s1, s2, s2_n;
  logic [LZC_W-1:0]         lzc, shamt;
  logic                     lz_all;
  logic [WIDTH-1:0]         shifted;
  logic [MAN_W-1:0]         mant, man_n;
  logic [MAN_W:0]           mant_r;
  logic                     guard, sticky, rnd;
  logic signed [SEXP_W-1:0] e_n;
  logic                     unused_msb;

  assign rdy3         = !vld_pipe[3] | io.out_ready;
  assign rdy2         = !vld_pipe[2] | rdy3;
  assign rdy1         = !vld_pipe[1] | rdy2;
  assign io.in_ready  = rdy1;
  assign io.out_valid = vld_pipe[3];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_pipe <= '0;
    end else begin
      if (rdy1) vld_pipe[1] <= io.in_valid;
      if (rdy2) vld_pipe[2] <= vld_pipe[1];
      if (rdy3) vld_pipe[3] <= vld_pipe[2];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1 <= '0;
    end else if (rdy1 && io.in_valid) begin
      s1.man    <= io.sum_in;
      s1.exp    <= SEXP_W'(io.exp_in);
      s1.sign   <= io.sign_in;
      s1.sticky <= 1'b0;
      s1.zero   <= (io.sum_in == '0);
    end
  end

  fp_lzc #(.W(WIDTH)) u_lzc (.din(s1.man[WIDTH-1:0]), .cnt(lzc), .all_zero(lz_all));

  // A zero beat is not shifted, so its exponent path stays quiet.
  always_comb begin
    s2_n    = s1;
    shamt   = lz_all ? '0 : lzc;
    shifted = s1.man[WIDTH-1:0] << shamt;
    if (s1.man[WIDTH]) begin
      s2_n.man    = {1'b0, s1.man[WIDTH:1]};
      s2_n.exp    = s1.exp + SEXP_W'(1);
      s2_n.sticky = s1.sticky | s1.man[0];
    end else begin
      s2_n.man = {1'b0, shifted};
      s2_n.exp = s1.exp - SEXP_W'(shamt);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                       s2 <= '0;
    else if (rdy2 && vld_pipe[1])  s2 <= s2_n;
  end

  // Bit WIDTH is always clear after normalisation.
  assign unused_msb = s2.man[WIDTH];

  always_comb begin
    mant   = s2.man[WIDTH-1 -: MAN_W];
    guard  = s2.man[WIDTH-MAN_W-1];
    sticky = s2.sticky | (|s2.man[WIDTH-MAN_W-2:0]);
    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + (MAN_W+1)'(rnd);
    man_n  = mant_r[MAN_W-1:0];
    e_n    = s2.exp;
    if (mant_r[MAN_W]) begin
      man_n = MAN_W'(1) << (MAN_W - 1);
      e_n   = s2.exp + SEXP_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      io.man_out  <= '0;
      io.exp_out  <= '0;
      io.sign_out <= 1'b0;
      io.zero     <= 1'b0;
      io.ovf      <= 1'b0;
      io.unf      <= 1'b0;
    end else if (rdy3 && vld_pipe[2]) begin
      io.man_out  <= man_n;
      io.exp_out  <= e_n[EXP_W-1:0];
      io.sign_out <= s2.sign;
      io.zero     <= 1'b0;
      io.ovf      <= 1'b0;
      io.unf      <= 1'b0;
      if (s2.zero) begin
        io.man_out  <= '0;
        io.exp_out  <= '0;
        io.sign_out <= 1'b0;
        io.zero     <= 1'b1;
      end else if (e_n >= SEXP_W'(EXP_MAX)) begin
        io.man_out <= '0;
        io.exp_out <= EXP_W'(EXP_MAX);
        io.ovf     <= 1'b1;
      end else if (e_n[SEXP_W-1] || e_n == SEXP_W'(0)) begin
        io.man_out <= '0;
        io.exp_out <= '0;
        io.unf     <= 1'b1;
      end
    end
  end
endmodule
